// File: rtl/fir_pkg.sv
// Shared FIR definitions: state encoding, accumulator sizing,
// and the round/saturate helpers used by the filter blocks.
package fir_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_e;

  function automatic int acc_width(
    input int dw,
    input int cw,
    input int taps
  );
    return dw + cw + $clog2(taps);
  endfunction

  // Round half up: add half an LSB of the result before shifting.
  function automatic logic signed [63:0] round_shift(
    input logic signed [63:0] v,
    input int                 sh
  );
    if (sh <= 0) return v;
    return (v + (64'sd1 <<< (sh - 1))) >>> sh;
  endfunction

  function automatic logic signed [63:0] saturate(
    input logic signed [63:0] v,
    input int                 w
  );
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/fir_mac_unit.sv
// Signed multiply-accumulate with clear/enable and a
// combinational round/saturate view of the next accumulator value.
module fir_mac_unit
  import fir_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int ACC_W  = 19,
  parameter int OUT_W  = 16,
  parameter int SHIFT  = 0
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     clr_i,
  input  logic                     en_i,
  input  logic signed [DATA_W-1:0] a_i,
  input  logic signed [COEF_W-1:0] b_i,
  output logic signed [OUT_W-1:0]  res_o
);

  logic signed [DATA_W+COEF_W-1:0] prod;
  logic signed [ACC_W-1:0]         acc_q;
  logic signed [ACC_W-1:0]         acc_d;

  assign prod = a_i * b_i;

  always_comb begin
    acc_d = acc_q;
    unique case (1'b1)
      clr_i:   acc_d = '0;
      en_i:    acc_d = acc_q + ACC_W'(prod);
      default: acc_d = acc_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) acc_q <= '0;
    else          acc_q <= acc_d;
  end

  // Taken from acc_d so the final product is included on the last MAC edge.
  assign res_o = OUT_W'(saturate(round_shift(64'(acc_d), SHIFT), OUT_W));

endmodule

// File: rtl/fir_filter_mac.sv
// Time-multiplexed signed FIR: one shared multiplier, TAPS
// cycles per sample, programmable coefficients, valid/ready.
module fir_filter_mac
  import fir_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int COEF_W   = 8,
  parameter int TAPS     = 8,
  parameter int OUT_W    = 16,
  parameter int SHIFT    = 0,
  parameter int COEF_RST = 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [DATA_W-1:0]  in_data,
  input  logic                      coef_we,
  input  logic [$clog2(TAPS)-1:0]   coef_addr,
  input  logic signed [COEF_W-1:0]  coef_wdata,
  output logic                      coef_err,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [OUT_W-1:0]   out_data,
  output logic                      busy
);

  localparam int ACC_W = acc_width(DATA_W, COEF_W, TAPS);
  localparam int AW    = $clog2(TAPS);

  state_e                    state_q, state_d;
  logic signed [DATA_W-1:0]  x_q    [TAPS];
  logic signed [COEF_W-1:0]  coef_q [TAPS];
  logic [AW-1:0]             k_q;
  logic signed [OUT_W-1:0]   out_q;
  logic signed [OUT_W-1:0]   res;
  logic                      err_q;
  logic                      accept;
  logic                      mac_en;
  logic                      last;
  logic                      in_range;
  logic                      wr_ok;

  assign accept   = in_valid && (state_q == IDLE);
  assign mac_en   = (state_q == MAC);
  assign last     = mac_en && (k_q == AW'(TAPS - 1));
  assign in_range = 32'(coef_addr) < 32'(TAPS);
  assign wr_ok    = coef_we && in_range && !mac_en;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = MAC;
      MAC:     if (last) state_d = OUT;
      OUT:     if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < TAPS; i++) x_q[i] <= '0;
    end else if (accept) begin
      x_q[0] <= in_data;
      for (int i = 1; i < TAPS; i++) x_q[i] <= x_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < TAPS; i++) coef_q[i] <= COEF_W'(COEF_RST);
    end else if (wr_ok) begin
      coef_q[coef_addr] <= coef_wdata;
    end
  end

  // k parks on the last tap so the operand mux never leaves the array.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      k_q   <= '0;
      out_q <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= coef_we && !wr_ok;
      if (accept)      k_q <= '0;
      else if (mac_en && !last) k_q <= k_q + 1'b1;
      if (last) out_q <= res;
    end
  end

  fir_mac_unit #(
    .DATA_W (DATA_W),
    .COEF_W (COEF_W),
    .ACC_W  (ACC_W),
    .OUT_W  (OUT_W),
    .SHIFT  (SHIFT)
  ) u_mac (
    .clk     (clk),
    .reset_n (reset_n),
    .clr_i   (accept),
    .en_i    (mac_en),
    .a_i     (x_q[k_q]),
    .b_i     (coef_q[k_q]),
    .res_o   (res)
  );

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == OUT);
  assign busy      = (state_q == MAC) || (state_q == OUT);
  assign out_data  = out_q;
  assign coef_err  = err_q;

endmodule

// File: tb/tb_fir_filter_mac.sv
// Directed-vector bench: TAPS=4 unshifted instance plus a
// TAPS=6, SHIFT=2 instance for rounding and address range.
module tb_fir_filter_mac;

  localparam int OP_RST = 0;
  localparam int OP_WR  = 1;
  localparam int OP_SMP = 2;
  localparam int OP_SWR = 3;

  typedef struct {
    int op;
    int addr;
    int wdata;
    int din;
    int exp;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  logic              in_valid = 1'b0;
  logic              in_ready;
  logic signed [7:0] in_data = '0;
  logic              coef_we = 1'b0;
  logic [1:0]        coef_addr = '0;
  logic signed [7:0] coef_wdata = '0;
  logic              coef_err;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic signed [15:0] out_data;
  logic              busy;

  logic              b_in_valid = 1'b0;
  logic              b_in_ready;
  logic signed [7:0] b_in_data = '0;
  logic              b_coef_we = 1'b0;
  logic [2:0]        b_coef_addr = '0;
  logic signed [7:0] b_coef_wdata = '0;
  logic              b_coef_err;
  logic              b_out_valid;
  logic              b_out_ready = 1'b1;
  logic signed [15:0] b_out_data;
  logic              b_busy;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fir_filter_mac #(
    .DATA_W(8), .COEF_W(8), .TAPS(4), .OUT_W(16),
    .SHIFT(0), .COEF_RST(1)
  ) u_dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .coef_we    (coef_we),
    .coef_addr  (coef_addr),
    .coef_wdata (coef_wdata),
    .coef_err   (coef_err),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .busy       (busy)
  );

  fir_filter_mac #(
    .DATA_W(8), .COEF_W(8), .TAPS(6), .OUT_W(16),
    .SHIFT(2), .COEF_RST(1)
  ) u_dut_b (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (b_in_valid),
    .in_ready   (b_in_ready),
    .in_data    (b_in_data),
    .coef_we    (b_coef_we),
    .coef_addr  (b_coef_addr),
    .coef_wdata (b_coef_wdata),
    .coef_err   (b_coef_err),
    .out_valid  (b_out_valid),
    .out_ready  (b_out_ready),
    .out_data   (b_out_data),
    .busy       (b_busy)
  );

  task automatic check(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic reset_dut();
    @(negedge clk);
    reset_n = 1'b0;
    in_valid = 1'b0;
    coef_we = 1'b0;
    b_in_valid = 1'b0;
    b_coef_we = 1'b0;
    out_ready = 1'b1;
    b_out_ready = 1'b1;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic wait_out(output bit to);
    int n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    to = !out_valid;
  endtask

  task automatic run_sample(
    input  bit                we,
    input  int                addr,
    input  int                wd,
    input  int                d,
    output logic signed [15:0] y,
    output bit                to
  );
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    in_valid = 1'b1;
    in_data = 8'(d);
    coef_we = we;
    coef_addr = 2'(addr);
    coef_wdata = 8'(wd);
    @(negedge clk);
    in_valid = 1'b0;
    in_data = 8'sh5A;
    coef_we = 1'b0;
    wait_out(to);
    y = out_data;
  endtask

  task automatic run_b(input int d, output logic signed [15:0] y, output bit to);
    int n = 0;
    @(negedge clk);
    while (!b_in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    b_in_valid = 1'b1;
    b_in_data = 8'(d);
    @(negedge clk);
    b_in_valid = 1'b0;
    n = 0;
    while (!b_out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    to = !b_out_valid;
    y = b_out_data;
  endtask

  vec_t vq[$];
  logic signed [15:0] y;
  bit to;
  int first_acc;
  int bad_v;
  int bad_r;

  initial begin
    vq.push_back('{OP_RST, 0, 0, 0, 0});
    vq.push_back('{OP_SMP, 0, 0, 10, 10});
    vq.push_back('{OP_SMP, 0, 0, 20, 30});
    vq.push_back('{OP_SMP, 0, 0, 30, 60});
    vq.push_back('{OP_SMP, 0, 0, 40, 100});
    vq.push_back('{OP_SMP, 0, 0, 50, 140});
    vq.push_back('{OP_RST, 0, 0, 0, 0});
    vq.push_back('{OP_WR, 0, 1, 0, 0});
    vq.push_back('{OP_WR, 1, 2, 0, 0});
    vq.push_back('{OP_WR, 2, 3, 0, 0});
    vq.push_back('{OP_WR, 3, 4, 0, 0});
    vq.push_back('{OP_SMP, 0, 0, 1, 1});
    vq.push_back('{OP_SMP, 0, 0, 0, 2});
    vq.push_back('{OP_SMP, 0, 0, 0, 3});
    vq.push_back('{OP_SMP, 0, 0, 0, 4});
    vq.push_back('{OP_SMP, 0, 0, 0, 0});
    for (int a = 0; a < 4; a++) vq.push_back('{OP_WR, a, 127, 0, 0});
    vq.push_back('{OP_SMP, 0, 0, 127, 16129});
    vq.push_back('{OP_SMP, 0, 0, 127, 32258});
    vq.push_back('{OP_SMP, 0, 0, 127, 32767});
    vq.push_back('{OP_SMP, 0, 0, 127, 32767});
    vq.push_back('{OP_SMP, 0, 0, -128, 32131});
    vq.push_back('{OP_SMP, 0, 0, -128, -254});
    vq.push_back('{OP_SMP, 0, 0, -128, -32639});
    vq.push_back('{OP_SMP, 0, 0, -128, -32768});
    vq.push_back('{OP_RST, 0, 0, 0, 0});
    vq.push_back('{OP_WR, 0, -1, 0, 0});
    vq.push_back('{OP_WR, 1, 2, 0, 0});
    vq.push_back('{OP_WR, 2, -3, 0, 0});
    vq.push_back('{OP_WR, 3, 4, 0, 0});
    vq.push_back('{OP_SMP, 0, 0, 5, -5});
    vq.push_back('{OP_SMP, 0, 0, -6, 16});
    vq.push_back('{OP_SMP, 0, 0, 7, -34});
    vq.push_back('{OP_SMP, 0, 0, 0, 52});
    vq.push_back('{OP_RST, 0, 0, 0, 0});
    vq.push_back('{OP_SWR, 0, 9, 3, 27});

    // Reset values
    @(negedge clk);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_coef_err", int'(coef_err), 0);
    check("rst_out_valid2", int'(out_valid), 0);

    foreach (vq[i]) begin
      case (vq[i].op)
        OP_RST: reset_dut();
        OP_WR: begin
          @(negedge clk);
          coef_we = 1'b1;
          coef_addr = 2'(vq[i].addr);
          coef_wdata = 8'(vq[i].wdata);
          @(negedge clk);
          coef_we = 1'b0;
          check($sformatf("vec%0d_err", i), int'(coef_err), 0);
        end
        default: begin
          run_sample(vq[i].op == OP_SWR, vq[i].addr, vq[i].wdata,
                     vq[i].din, y, to);
          check($sformatf("vec%0d_timeout", i), int'(to), 0);
          check($sformatf("vec%0d_out", i), int'(y), vq[i].exp);
        end
      endcase
    end

    // Throughput with in_valid and out_ready held high
    reset_dut();
    @(negedge clk);
    in_valid = 1'b1;
    in_data = 8'sd1;
    first_acc = -1;
    begin
      int gap = -1;
      for (int c = 0; c < 40 && gap < 0; c++) begin
        if (in_ready) begin
          if (first_acc < 0) first_acc = c;
          else gap = c - first_acc;
        end
        if (gap < 0) @(negedge clk);
      end
      @(negedge clk);
      in_valid = 1'b0;
      check("throughput_gap", gap, 6);
      check("busy_in_mac", int'(busy), 1);
    end
    wait_out(to);
    check("throughput_drain", int'(to), 0);
    @(negedge clk);

    // Stall: out_ready low for 20 cycles
    reset_dut();
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data = 8'sd7;
    @(negedge clk);
    in_data = 8'sd100;
    wait_out(to);
    check("stall_timeout", int'(to), 0);
    check("stall_out", int'(out_data), 7);
    y = out_data;
    bad_v = 0;
    bad_r = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (!out_valid || out_data != y) bad_v++;
      if (in_ready) bad_r++;
    end
    check("stall_hold", bad_v, 0);
    check("stall_in_ready", bad_r, 0);
    out_ready = 1'b1;
    @(negedge clk);
    check("stall_release_valid", int'(out_valid), 0);
    check("stall_release_ready", int'(in_ready), 1);
    @(negedge clk);
    in_valid = 1'b0;
    wait_out(to);
    check("stall_next_timeout", int'(to), 0);
    check("stall_next_out", int'(out_data), 107);

    // Coefficient write during MAC is rejected
    reset_dut();
    @(negedge clk);
    in_valid = 1'b1;
    in_data = 8'sd2;
    @(negedge clk);
    in_valid = 1'b0;
    coef_we = 1'b1;
    coef_addr = 2'd0;
    coef_wdata = 8'sd99;
    check("mac_busy", int'(busy), 1);
    @(negedge clk);
    coef_we = 1'b0;
    check("mac_err_pulse", int'(coef_err), 1);
    @(negedge clk);
    check("mac_err_clear", int'(coef_err), 0);
    wait_out(to);
    check("mac_wr_out", int'(out_data), 2);
    run_sample(1'b0, 0, 0, 3, y, to);
    check("mac_wr_next", int'(y), 5);

    // Reset mid-MAC discards work and restores coefficients
    reset_dut();
    @(negedge clk);
    coef_we = 1'b1;
    coef_addr = 2'd0;
    coef_wdata = 8'sd4;
    @(negedge clk);
    coef_we = 1'b0;
    in_valid = 1'b1;
    in_data = 8'sd6;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check("midrst_valid", int'(out_valid), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_data", int'(out_data), 0);
    reset_n = 1'b1;
    run_sample(1'b0, 0, 0, 5, y, to);
    check("midrst_timeout", int'(to), 0);
    check("midrst_next", int'(y), 5);

    // SHIFT=2, TAPS=6 instance: rounding and out-of-range address
    reset_dut();
    begin
      int din [5] = '{1, 1, 1, 3, -13};
      int exp [5] = '{0, 1, 1, 2, -2};
      for (int i = 0; i < 5; i++) begin
        run_b(din[i], y, to);
        check($sformatf("round%0d_timeout", i), int'(to), 0);
        check($sformatf("round%0d_out", i), int'(y), exp[i]);
      end
    end
    @(negedge clk);
    b_coef_we = 1'b1;
    b_coef_addr = 3'd6;
    b_coef_wdata = 8'sd50;
    @(negedge clk);
    b_coef_we = 1'b0;
    check("range_err_pulse", int'(b_coef_err), 1);
    @(negedge clk);
    check("range_err_clear", int'(b_coef_err), 0);
    run_b(0, y, to);
    check("range_next_out", int'(y), -2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
